// File: rtl/shift_scheduler.sv
// Round-robin scheduler sharing one shift datapath among NUM_REQ requesters, with a single-entry output register.
// Optional rotate-left support for op 11 is compiled when SHIFT_SCHEDULER_ROTATE_EN is defined.
module shift_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SFT_WIDTH  = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              iReqVld,
   output logic [NUM_REQ-1:0]              oReqRdy,
   input  logic [NUM_REQ*2-1:0]            iReqOp,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   iReqDat,
   input  logic [NUM_REQ*SFT_WIDTH-1:0]    iReqSft,
   output logic                            oRspVld,
   input  logic                            iRspRdy,
   output logic [DATA_WIDTH-1:0]           oRspDat,
   output logic [$clog2(NUM_REQ)-1:0]      oRspId,
   output logic                            oRspErr
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   typedef struct packed {
      logic                  err;
      logic [ID_W-1:0]       id;
      logic [DATA_WIDTH-1:0] dat;
   } rsp_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       ptr, ptr_nxt, winner;
   logic                  found, grant;
   logic [1:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_dat, res;
   logic [SFT_WIDTH-1:0]  sel_sft;
   logic                  res_err;
   rsp_t                  rsp_q, rsp_nxt;

   logic [1:0]            op_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] dat_arr [NUM_REQ];
   logic [SFT_WIDTH-1:0]  sft_arr [NUM_REQ];

   // Unpack per-requester slices
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g]  = iReqOp[g*2 +: 2];
      assign dat_arr[g] = iReqDat[g*DATA_WIDTH +: DATA_WIDTH];
      assign sft_arr[g] = iReqSft[g*SFT_WIDTH +: SFT_WIDTH];
   end

   // Round-robin search upward from ptr, wrapping at NUM_REQ
   always_comb begin
      int unsigned idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && iReqVld[ID_W'(idx)]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   assign grant   = found && ((state == EMPTY) || iRspRdy);
   assign sel_op  = op_arr[winner];
   assign sel_dat = dat_arr[winner];
   assign sel_sft = sft_arr[winner];

   always_comb begin
      oReqRdy = '0;
      if (grant && rst_n) oReqRdy[winner] = 1'b1;
   end

   // Shift unit; Verilog shift semantics already saturate for amounts >= DATA_WIDTH
   always_comb begin
`ifdef SHIFT_SCHEDULER_ROTATE_EN
      int unsigned rot;
      rot = 32'(sel_sft) % DATA_WIDTH;
`endif
      res     = '0;
      res_err = 1'b0;
      case (sel_op)
         2'b00:   res = sel_dat >> sel_sft;
         2'b01:   res = $signed(sel_dat) >>> sel_sft;
         2'b10:   res = sel_dat << sel_sft;
         default: begin
`ifdef SHIFT_SCHEDULER_ROTATE_EN
            res = (sel_dat << rot) | (sel_dat >> (DATA_WIDTH - rot));
`else
            res_err = 1'b1;
`endif
         end
      endcase
   end

   // Next state: refill on grant, drain to EMPTY only when nothing replaces the result
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      rsp_nxt   = rsp_q;
      if (grant) begin
         state_nxt   = FULL;
         ptr_nxt     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
         rsp_nxt.err = res_err;
         rsp_nxt.id  = winner;
         rsp_nxt.dat = res;
      end else if ((state == FULL) && iRspRdy) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         ptr   <= '0;
         rsp_q <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         rsp_q <= rsp_nxt;
      end
   end

   assign oRspVld = (state == FULL);
   assign oRspDat = rsp_q.dat;
   assign oRspId  = rsp_q.id;
   assign oRspErr = rsp_q.err;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: op tables on a 4x32 and a 2x16 instance, plus fairness,
// backpressure and mid-operation reset sequences.
module tb_shift_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Main instance: NUM_REQ=4, DATA_WIDTH=32, SFT_WIDTH=5
   logic [3:0]   req_vld, req_rdy;
   logic [7:0]   req_op;
   logic [127:0] req_dat;
   logic [19:0]  req_sft;
   logic         rsp_vld, rsp_rdy, rsp_err;
   logic [31:0]  rsp_dat;
   logic [1:0]   rsp_id;

   // Narrow instance: NUM_REQ=2, DATA_WIDTH=16, SFT_WIDTH=5
   logic [1:0]   s_req_vld, s_req_rdy;
   logic [3:0]   s_req_op;
   logic [31:0]  s_req_dat;
   logic [9:0]   s_req_sft;
   logic         s_rsp_vld, s_rsp_rdy, s_rsp_err;
   logic [15:0]  s_rsp_dat;
   logic [0:0]   s_rsp_id;

   shift_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .SFT_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .iReqVld(req_vld), .oReqRdy(req_rdy), .iReqOp(req_op), .iReqDat(req_dat), .iReqSft(req_sft),
      .oRspVld(rsp_vld), .iRspRdy(rsp_rdy), .oRspDat(rsp_dat), .oRspId(rsp_id), .oRspErr(rsp_err)
   );

   shift_scheduler #(.NUM_REQ(2), .DATA_WIDTH(16), .SFT_WIDTH(5)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .iReqVld(s_req_vld), .oReqRdy(s_req_rdy), .iReqOp(s_req_op), .iReqDat(s_req_dat),
      .iReqSft(s_req_sft), .oRspVld(s_rsp_vld), .iRspRdy(s_rsp_rdy), .oRspDat(s_rsp_dat),
      .oRspId(s_rsp_id), .oRspErr(s_rsp_err)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] dat;
      logic [4:0]  sft;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs  [10];
   vec_t svecs [4];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int i, input logic [1:0] op, input logic [31:0] dat,
                            input logic [4:0] sft);
      req_op[i*2 +: 2]   = op;
      req_dat[i*32 +: 32] = dat;
      req_sft[i*5 +: 5]  = sft;
      req_vld[i]         = 1'b1;
   endtask

   initial begin
      vecs[0] = '{2'b01, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0};
      vecs[1] = '{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[2] = '{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[3] = '{2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[4] = '{2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
      vecs[5] = '{2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
      vecs[6] = '{2'b10, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
`ifdef SHIFT_SCHEDULER_ROTATE_EN
      vecs[7] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0};
`else
      vecs[7] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0000, 1'b1};
`endif
      vecs[8] = '{2'b10, 32'hF0F0_F0F0, 5'd4,  32'h0F0F_0F00, 1'b0};
      vecs[9] = '{2'b00, 32'hF0F0_F0F0, 5'd8,  32'h00F0_F0F0, 1'b0};

      svecs[0] = '{2'b00, 32'h0000_8001, 5'd20, 32'h0000_0000, 1'b0};
      svecs[1] = '{2'b01, 32'h0000_8001, 5'd20, 32'h0000_FFFF, 1'b0};
      svecs[2] = '{2'b10, 32'h0000_8001, 5'd20, 32'h0000_0000, 1'b0};
      svecs[3] = '{2'b01, 32'h0000_7FFF, 5'd16, 32'h0000_0000, 1'b0};

      rst_n     = 1'b0;
      req_vld   = 4'hF;
      req_op    = '0;
      req_dat   = '0;
      req_sft   = '0;
      rsp_rdy   = 1'b1;
      s_req_vld = '0;
      s_req_op  = '0;
      s_req_dat = '0;
      s_req_sft = '0;
      s_rsp_rdy = 1'b1;

      // Reset values, with requests pending
      #1;
      check("reset_vld", 32'(rsp_vld), 32'd0);
      check("reset_rdy", 32'(req_rdy), 32'd0);
      check("reset_dat", rsp_dat, 32'd0);
      check("reset_id",  32'(rsp_id), 32'd0);
      check("reset_err", 32'(rsp_err), 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // Fairness: all four valid, expect grants 0,1,2,3,0 back to back
      for (int i = 0; i < 4; i++) drive_req(i, 2'b00, 32'h100 + 32'(i), 5'd0);
      #1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("fair_rdy%0d", c), 32'(req_rdy), 32'(1) << (c % 4));
         if (c > 0) begin
            check($sformatf("fair_vld%0d", c), 32'(rsp_vld), 32'd1);
            check($sformatf("fair_id%0d", c), 32'(rsp_id), 32'((c - 1) % 4));
            check($sformatf("fair_dat%0d", c), rsp_dat, 32'h100 + 32'((c - 1) % 4));
         end
         step();
      end
      check("fair_id_last", 32'(rsp_id), 32'd0);
      req_vld = '0;
      step();
      check("fair_drain", 32'(rsp_vld), 32'd0);

      // Op table on requester 0, downstream always ready
      for (int i = 0; i < 10; i++) begin
         drive_req(0, vecs[i].op, vecs[i].dat, vecs[i].sft);
         #1;
         check($sformatf("vec%0d_rdy", i), 32'(req_rdy), 32'd1);
         step();
         req_vld = '0;
         check($sformatf("vec%0d_vld", i), 32'(rsp_vld), 32'd1);
         check($sformatf("vec%0d_dat", i), rsp_dat, vecs[i].exp);
         check($sformatf("vec%0d_id", i), 32'(rsp_id), 32'd0);
         check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
      end
      step();
      check("table_drain", 32'(rsp_vld), 32'd0);

      // Narrow instance: amounts beyond the 16-bit width
      for (int i = 0; i < 4; i++) begin
         s_req_op[1:0]  = svecs[i].op;
         s_req_dat[15:0] = svecs[i].dat[15:0];
         s_req_sft[4:0] = svecs[i].sft;
         s_req_vld      = 2'b01;
         #1;
         check($sformatf("svec%0d_rdy", i), 32'(s_req_rdy), 32'd1);
         step();
         s_req_vld = '0;
         check($sformatf("svec%0d_vld", i), 32'(s_rsp_vld), 32'd1);
         check($sformatf("svec%0d_dat", i), 32'(s_rsp_dat), svecs[i].exp);
         check($sformatf("svec%0d_err", i), 32'(s_rsp_err), 32'(svecs[i].err));
      end

      // Backpressure: hold FULL for 5 cycles while req2 waits, then drain and refill together
      rsp_rdy = 1'b0;
      drive_req(2, 2'b10, 32'h1, 5'd2);
      #1;
      check("bp_first_rdy", 32'(req_rdy), 32'h4);
      step();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp_hold_rdy%0d", c), 32'(req_rdy), 32'd0);
         check($sformatf("bp_hold_vld%0d", c), 32'(rsp_vld), 32'd1);
         check($sformatf("bp_hold_dat%0d", c), rsp_dat, 32'h4);
         check($sformatf("bp_hold_id%0d", c), 32'(rsp_id), 32'd2);
         step();
      end
      drive_req(2, 2'b10, 32'h10, 5'd1);
      rsp_rdy = 1'b1;
      #1;
      check("bp_refill_rdy", 32'(req_rdy), 32'h4);
      check("bp_refill_old", rsp_dat, 32'h4);
      step();
      req_vld = '0;
      check("bp_new_vld", 32'(rsp_vld), 32'd1);
      check("bp_new_dat", rsp_dat, 32'h20);
      check("bp_new_id", 32'(rsp_id), 32'd2);
      step();
      check("bp_drain", 32'(rsp_vld), 32'd0);

      // Reset while FULL: result discarded, pointer back to 0
      rsp_rdy = 1'b0;
      drive_req(0, 2'b00, 32'hAA, 5'd0);
      #1;
      step();
      check("rst_pre_vld", 32'(rsp_vld), 32'd1);
      check("rst_pre_dat", rsp_dat, 32'hAA);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_vld", 32'(rsp_vld), 32'd0);
      check("rst_mid_dat", rsp_dat, 32'd0);
      check("rst_mid_rdy", 32'(req_rdy), 32'd0);
      step();
      rst_n   = 1'b1;
      req_vld = '0;
      drive_req(1, 2'b00, 32'h11, 5'd0);
      drive_req(0, 2'b00, 32'h22, 5'd0);
      rsp_rdy = 1'b1;
      #1;
      check("rst_post_vld", 32'(rsp_vld), 32'd0);
      check("rst_post_rdy", 32'(req_rdy), 32'h1);
      step();
      check("rst_g0_id", 32'(rsp_id), 32'd0);
      check("rst_g0_dat", rsp_dat, 32'h22);
      check("rst_g1_rdy", 32'(req_rdy), 32'h2);
      step();
      req_vld = '0;
      check("rst_g1_id", 32'(rsp_id), 32'd1);
      check("rst_g1_dat", rsp_dat, 32'h11);
      step();
      check("rst_drain", 32'(rsp_vld), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_scheduler.md
SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one shift datapath (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand and result width.
REQ-003 SHALL have parameter SFT_WIDTH, default 5, shift-amount width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port iReqVld  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port oReqRdy  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 SHALL have port iReqOp  input  NUM_REQ*2  per-requester op: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate left.
REQ-009 SHALL have port iReqDat  input  NUM_REQ*DATA_WIDTH  per-requester operand, requester i in slice i.
REQ-010 SHALL have port iReqSft  input  NUM_REQ*SFT_WIDTH  per-requester shift amount.
REQ-011 SHALL have port oRspVld  output  1  result valid.
REQ-012 SHALL have port iRspRdy  input  1  downstream accept.
REQ-013 SHALL have port oRspDat  output  DATA_WIDTH  shift result.
REQ-014 SHALL have port oRspId  output  $clog2(NUM_REQ)  index of requester owning the result.
REQ-015 SHALL have port oRspErr  output  1  result came from an unsupported op.

Function
REQ-016 SHALL transfer a request on cycle where iReqVld[i] & oReqRdy[i]; response transfers where oRspVld & iRspRdy.
REQ-017 SHALL hold a single-entry output register with states EMPTY (oRspVld=0) and FULL (oRspVld=1).
REQ-018 SHALL assert a grant only when state is EMPTY or iRspRdy=1 (drain and refill in the same cycle, full throughput).
REQ-019 SHALL pick the grant round-robin: search upward from pointer ptr, wrapping at NUM_REQ; ptr resets to 0 and becomes winner+1 (mod NUM_REQ) after each grant.
REQ-020 SHALL drive oReqRdy combinationally from iReqVld, state, iRspRdy and ptr; oReqRdy[i]=0 whenever iReqVld[i]=0.
REQ-021 SHALL present the result one cycle after acceptance (latency 1), oRspId = granted index.
REQ-022 SHALL keep oRspDat/oRspId/oRspErr stable while oRspVld=1 and iRspRdy=0.
REQ-023 SHALL go FULL->EMPTY only on response transfer with no same-cycle grant.
REQ-024 SHALL compute logical right as zero-fill, arithmetic right as fill with operand MSB, left as zero-fill into LSBs.
REQ-025 SHALL, for amount >= DATA_WIDTH: logical right/left -> all zeros, arithmetic right -> all copies of MSB; amount 0 -> operand unchanged.
REQ-026 SHALL bound waiting: a requester holding iReqVld is granted within NUM_REQ grants.

Reset
REQ-027 SHALL, while rst_n=0, force state EMPTY, ptr=0, oRspVld=0, oRspDat=0, oRspId=0, oRspErr=0, oReqRdy=0, independent of clk.
REQ-028 SHALL discard any in-flight result on reset assertion mid-operation; no response for it after release.
REQ-029 SHALL accept requests on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile rotate support when macro SHIFT_SCHEDULER_ROTATE_EN is defined: op 11 gives rotate left by amount mod DATA_WIDTH, oRspErr=0.
REQ-031 SHALL, without SHIFT_SCHEDULER_ROTATE_EN, accept op 11 normally but return oRspDat=0, oRspErr=1; other ops unaffected.

Verification
REQ-032 SHALL cover single op: req0 vld, op 01, dat 0x8000_00F0, sft 4, iRspRdy=1 -> next cycle oRspVld=1, dat 0xF800_000F, id 0, err 0.
REQ-033 SHALL cover fairness: all 4 requesters vld continuously, iRspRdy=1 -> grant order 0,1,2,3,0 one per cycle, no bubbles.
REQ-034 SHALL cover backpressure: FULL with iRspRdy=0 for 5 cycles while req2 vld -> oReqRdy=0, outputs stable; on iRspRdy=1, result drains and req2 granted same cycle.
REQ-035 SHALL cover op 11, dat 0x8000_0001, sft 1 -> with macro 0x0000_0003 err 0; without macro 0x0 err 1.
REQ-036 SHALL cover reset mid-operation: rst_n low while FULL -> oRspVld=0 immediately, ptr=0; after release req1 then req0 vld -> req0 granted first.
REQ-037 SHALL cover boundaries: sft 0 on 0x1234_5678 -> unchanged for ops 00/01/10; DATA_WIDTH=16, SFT_WIDTH=5, sft 20 on 0x8001 -> 00:0x0000, 01:0xFFFF, 10:0x0000.
